// File: rtl/sdcard_photo_loader.sv
// Loads PHOTO_NUM raw 16-bit images from consecutive SD sectors into per-image SDRAM regions.
// all_photo_en goes high once the last sector of the last image has been streamed out.
module sdcard_photo_loader #(
    parameter int          PHOTO_NUM    = 8,
    parameter int          PHOTO_WORDS  = 786432,
    parameter int          SECTOR_WORDS = 256,
    parameter logic [31:0] BASE_SECTOR  = 32'd16384
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        rd_busy,
    input  logic        rd_data_en,
    input  logic [15:0] rd_data,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic        sdram_wr_en,
    output logic [15:0] sdram_wr_data,
    output logic [22:0] sdram_wr_b_addr,
    output logic [22:0] sdram_wr_e_addr,
    output logic [2:0]  photo_idx,
    output logic        all_photo_en
);
    localparam int PHOTO_SECTORS = PHOTO_WORDS / SECTOR_WORDS;
    localparam int SEC_W         = $clog2(PHOTO_SECTORS + 1);
    localparam int WRD_W         = $clog2(SECTOR_WORDS + 1);

    localparam logic [SEC_W-1:0] LAST_SECTOR = SEC_W'(PHOTO_SECTORS - 1);
    localparam logic [2:0]       LAST_PHOTO  = 3'(PHOTO_NUM - 1);
    localparam logic [WRD_W-1:0] SECTOR_FULL = WRD_W'(SECTOR_WORDS);
    localparam logic [22:0]      REGION_LAST = 23'(PHOTO_WORDS - 1);

    typedef enum logic [2:0] {WAIT_INIT, REQ, WAIT_BUSY, READ, NEXT, DONE} state_t;

    state_t           state, next_state;
    logic [SEC_W-1:0] sector_cnt;
    logic [WRD_W-1:0] word_cnt;
    logic             abort;
    logic             last_sector;
    logic             last_photo;
    logic             beat_ok;
    logic [22:0]      region_base;

    // Losing init_end restarts everything, except once all images are resident.
    assign abort       = !init_end && (state != DONE);
    assign last_sector = (sector_cnt == LAST_SECTOR);
    assign last_photo  = (photo_idx == LAST_PHOTO);
    assign beat_ok     = rd_data_en && init_end && (word_cnt < SECTOR_FULL) &&
                         ((state == WAIT_BUSY) || (state == READ));
    assign region_base = 23'(photo_idx) * 23'(PHOTO_WORDS);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= WAIT_INIT;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_req     = 1'b0;
        case (state)
            WAIT_INIT: if (init_end) next_state = REQ;
            REQ: begin
                rd_req     = init_end;
                next_state = WAIT_BUSY;
            end
            WAIT_BUSY: if (rd_busy) next_state = READ;
            READ:      if (!rd_busy) next_state = NEXT;
            NEXT:      next_state = (last_sector && last_photo) ? DONE : REQ;
            DONE:      next_state = DONE;
            default:   next_state = WAIT_INIT;
        endcase
        if (abort) next_state = WAIT_INIT;
    end

    // Images are contiguous on the card, so the sector address simply steps by one.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            photo_idx    <= '0;
            sector_cnt   <= '0;
            word_cnt     <= '0;
            rd_addr      <= '0;
            all_photo_en <= 1'b0;
        end else if (abort) begin
            photo_idx  <= '0;
            sector_cnt <= '0;
            word_cnt   <= '0;
        end else begin
            case (state)
                WAIT_INIT: begin
                    rd_addr  <= BASE_SECTOR;
                    word_cnt <= '0;
                end
                REQ: word_cnt <= '0;
                WAIT_BUSY, READ: if (beat_ok) word_cnt <= word_cnt + 1'b1;
                NEXT: begin
                    if (!(last_sector && last_photo)) rd_addr <= rd_addr + 32'd1;
                    if (!last_sector) begin
                        sector_cnt <= sector_cnt + 1'b1;
                    end else begin
                        sector_cnt <= '0;
                        if (!last_photo) photo_idx <= photo_idx + 3'd1;
                        else             all_photo_en <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage boundary: SD beat -> SDRAM push, one cycle later; region bounds follow photo_idx.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sdram_wr_en     <= 1'b0;
            sdram_wr_data   <= '0;
            sdram_wr_b_addr <= '0;
            sdram_wr_e_addr <= REGION_LAST;
        end else begin
            sdram_wr_en     <= beat_ok;
            if (beat_ok) sdram_wr_data <= rd_data;
            sdram_wr_b_addr <= region_base;
            sdram_wr_e_addr <= region_base + REGION_LAST;
        end
    end

endmodule

// File: tb/tb_sdcard_photo_loader.sv
// Directed bench for sdcard_photo_loader: a small SD sector-read model feeds beats,
// a monitor logs requests and SDRAM pushes, and scenario tasks compare against hand-derived values.
module tb_sdcard_photo_loader;
    localparam int          PHOTO_NUM    = 8;
    localparam int          PHOTO_WORDS  = 512;
    localparam int          SECTOR_WORDS = 256;
    localparam logic [31:0] BASE_SECTOR  = 32'd100;
    localparam int          TOTAL_SECT   = 16;
    localparam int          TOTAL_WORDS  = 4096;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        init_end   = 1'b0;
    logic        rd_busy    = 1'b0;
    logic        rd_data_en = 1'b0;
    logic [15:0] rd_data    = 16'h0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        sdram_wr_en;
    logic [15:0] sdram_wr_data;
    logic [22:0] sdram_wr_b_addr;
    logic [22:0] sdram_wr_e_addr;
    logic [2:0]  photo_idx;
    logic        all_photo_en;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // SD model controls (written by the main sequence only)
    int first_beats = 256;
    int busy_delay  = 2;
    int load_id     = 0;

    // SD model state (written by the model only)
    bit          m_active = 1'b0;
    int          m_wait = 0, m_sent = 0, m_beats = 0, seen_load = -1;
    int          last_fall = 0;
    logic [15:0] sd_word = 16'h1000;
    logic [15:0] exp_data[$];
    int          exp_cyc[$];

    // Monitor logs (written by the monitor only)
    logic [31:0] req_q[$];
    logic [15:0] act_data[$];
    int          act_cyc[$];
    logic [22:0] b_hist[$];
    logic [22:0] prev_b = 23'h0;
    logic        prev_all = 1'b0;
    int          all_rise = -1;

    sdcard_photo_loader #(
        .PHOTO_NUM   (PHOTO_NUM),
        .PHOTO_WORDS (PHOTO_WORDS),
        .SECTOR_WORDS(SECTOR_WORDS),
        .BASE_SECTOR (BASE_SECTOR)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .init_end       (init_end),
        .rd_busy        (rd_busy),
        .rd_data_en     (rd_data_en),
        .rd_data        (rd_data),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .sdram_wr_en    (sdram_wr_en),
        .sdram_wr_data  (sdram_wr_data),
        .sdram_wr_b_addr(sdram_wr_b_addr),
        .sdram_wr_e_addr(sdram_wr_e_addr),
        .photo_idx      (photo_idx),
        .all_photo_en   (all_photo_en)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // SD sector-read model: on rd_req, raises busy (immediately or after busy_delay cycles),
    // streams m_beats words, then drops busy. Expected pushes are the first SECTOR_WORDS beats.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (m_active) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else if (m_sent < m_beats) begin
                    rd_busy    = 1'b1;
                    rd_data_en = 1'b1;
                    rd_data    = sd_word;
                    if (m_sent < SECTOR_WORDS && init_end) begin
                        exp_data.push_back(sd_word);
                        exp_cyc.push_back(cyc);
                    end
                    sd_word = sd_word + 16'd1;
                    m_sent++;
                end else begin
                    rd_data_en = 1'b0;
                    rd_busy    = 1'b0;
                    m_active   = 1'b0;
                    last_fall  = cyc;
                end
            end else if (rd_req === 1'b1) begin
                m_active = 1'b1;
                m_sent   = 0;
                if (seen_load != load_id) begin
                    m_beats   = first_beats;
                    seen_load = load_id;
                end else begin
                    m_beats = SECTOR_WORDS;
                end
                if (busy_delay == 0) begin
                    rd_busy = 1'b1;
                    m_wait  = 0;
                end else begin
                    m_wait = busy_delay;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (rd_req === 1'b1) req_q.push_back(rd_addr);
            if (sdram_wr_en === 1'b1) begin
                act_data.push_back(sdram_wr_data);
                act_cyc.push_back(cyc);
            end
            if (sdram_wr_b_addr !== prev_b) begin
                b_hist.push_back(sdram_wr_b_addr);
                prev_b = sdram_wr_b_addr;
            end
            if (all_photo_en === 1'b1 && prev_all !== 1'b1) all_rise = cyc;
            prev_all = all_photo_en;
        end
    end

    task automatic do_reset();
        @(negedge sys_clk) sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_all(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge sys_clk);
            if (all_photo_en === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge sys_clk);
            if (!m_active) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int r0;
        init_end  = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
        vectors++; if (sdram_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b expected 0", sdram_wr_en); end
        vectors++; if (all_photo_en !== 1'b0) begin miscompares++; $display("FAIL reset_all_en: got %b expected 0", all_photo_en); end
        vectors++; if (sdram_wr_e_addr !== 23'd511) begin miscompares++; $display("FAIL reset_e_addr: got %0d expected 511", sdram_wr_e_addr); end
        vectors++; if (sdram_wr_b_addr !== 23'd0) begin miscompares++; $display("FAIL reset_b_addr: got %0d expected 0", sdram_wr_b_addr); end
        vectors++; if (rd_addr !== 32'd0) begin miscompares++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        vectors++; if (photo_idx !== 3'd0) begin miscompares++; $display("FAIL reset_photo_idx: got %0d expected 0", photo_idx); end
        vectors++; if (sdram_wr_data !== 16'd0) begin miscompares++; $display("FAIL reset_wr_data: got %0d expected 0", sdram_wr_data); end
        r0 = req_q.size();
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        vectors++; if (req_q.size() != r0) begin miscompares++; $display("FAIL idle_no_req: got %0d requests expected 0", req_q.size() - r0); end
    endtask

    task automatic test_full_load(input int beats0, input int delay, input string tag);
        int  r0, p0, e0, b0, n;
        bit  ok;
        wait_idle(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL %s_model_idle: got busy expected idle", tag); end
        first_beats = beats0;
        busy_delay  = delay;
        load_id++;
        r0 = req_q.size(); p0 = act_data.size(); e0 = exp_data.size(); b0 = b_hist.size();
        @(negedge sys_clk) init_end = 1'b1;
        wait_all(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL %s_all_en_timeout: got 0 expected 1", tag); end
        repeat (2) @(negedge sys_clk);
        vectors++; if (req_q.size() - r0 != TOTAL_SECT) begin miscompares++; $display("FAIL %s_req_count: got %0d expected %0d", tag, req_q.size() - r0, TOTAL_SECT); end
        n = (req_q.size() - r0 < TOTAL_SECT) ? req_q.size() - r0 : TOTAL_SECT;
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (req_q[r0 + i] !== BASE_SECTOR + 32'(i)) begin
                miscompares++; $display("FAIL %s_rd_addr[%0d]: got %0d expected %0d", tag, i, req_q[r0 + i], BASE_SECTOR + 32'(i));
            end
        end
        vectors++; if (act_data.size() - p0 != TOTAL_WORDS) begin miscompares++; $display("FAIL %s_push_count: got %0d expected %0d", tag, act_data.size() - p0, TOTAL_WORDS); end
        n = act_data.size() - p0;
        if (exp_data.size() - e0 < n) n = exp_data.size() - e0;
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (act_data[p0 + i] !== exp_data[e0 + i] || act_cyc[p0 + i] != exp_cyc[e0 + i] + 1) begin
                miscompares++;
                $display("FAIL %s_push[%0d]: got %h@%0d expected %h@%0d", tag, i, act_data[p0 + i], act_cyc[p0 + i], exp_data[e0 + i], exp_cyc[e0 + i] + 1);
            end
        end
        vectors++; if (b_hist.size() - b0 != PHOTO_NUM - 1) begin miscompares++; $display("FAIL %s_b_addr_steps: got %0d expected %0d", tag, b_hist.size() - b0, PHOTO_NUM - 1); end
        n = (b_hist.size() - b0 < PHOTO_NUM - 1) ? b_hist.size() - b0 : PHOTO_NUM - 1;
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (b_hist[b0 + i] !== 23'((i + 1) * PHOTO_WORDS)) begin
                miscompares++; $display("FAIL %s_b_addr[%0d]: got %0d expected %0d", tag, i + 1, b_hist[b0 + i], (i + 1) * PHOTO_WORDS);
            end
        end
        vectors++; if (sdram_wr_e_addr !== 23'd4095) begin miscompares++; $display("FAIL %s_e_addr_final: got %0d expected 4095", tag, sdram_wr_e_addr); end
        vectors++; if (all_rise != last_fall + 2) begin miscompares++; $display("FAIL %s_all_en_timing: got cycle %0d expected %0d", tag, all_rise, last_fall + 2); end
        vectors++; if (photo_idx !== 3'd7) begin miscompares++; $display("FAIL %s_photo_idx_final: got %0d expected 7", tag, photo_idx); end
        vectors++; if (rd_addr !== 32'd115) begin miscompares++; $display("FAIL %s_rd_addr_hold: got %0d expected 115", tag, rd_addr); end
    endtask

    task automatic test_done_hold();
        int r0;
        r0 = req_q.size();
        @(negedge sys_clk) init_end = 1'b0;
        repeat (20) @(negedge sys_clk);
        vectors++; if (all_photo_en !== 1'b1) begin miscompares++; $display("FAIL done_hold_all_en: got %b expected 1", all_photo_en); end
        vectors++; if (req_q.size() != r0) begin miscompares++; $display("FAIL done_hold_req: got %0d requests expected 0", req_q.size() - r0); end
        init_end = 1'b1;
        repeat (5) @(negedge sys_clk);
        vectors++; if (req_q.size() != r0) begin miscompares++; $display("FAIL done_reraise_req: got %0d requests expected 0", req_q.size() - r0); end
    endtask

    task automatic test_reset_after_done();
        int r0, p0;
        bit ok;
        first_beats = SECTOR_WORDS;
        busy_delay  = 2;
        load_id++;
        r0 = req_q.size(); p0 = act_data.size();
        @(negedge sys_clk) sys_rst_n = 1'b0;
        @(negedge sys_clk);
        vectors++; if (all_photo_en !== 1'b0) begin miscompares++; $display("FAIL rst_after_done_all_en: got %b expected 0", all_photo_en); end
        sys_rst_n = 1'b1;
        wait_all(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL reload_timeout: got 0 expected 1"); end
        vectors++; if (req_q.size() - r0 != TOTAL_SECT) begin miscompares++; $display("FAIL reload_req_count: got %0d expected %0d", req_q.size() - r0, TOTAL_SECT); end
        if (req_q.size() > r0) begin
            vectors++; if (req_q[r0] !== 32'd100) begin miscompares++; $display("FAIL reload_first_addr: got %0d expected 100", req_q[r0]); end
        end
        repeat (2) @(negedge sys_clk);
        vectors++; if (act_data.size() - p0 != TOTAL_WORDS) begin miscompares++; $display("FAIL reload_push_count: got %0d expected %0d", act_data.size() - p0, TOTAL_WORDS); end
    endtask

    task automatic test_overlong();
        @(negedge sys_clk) init_end = 1'b0;
        do_reset();
        test_full_load(260, 2, "overlong");
    endtask

    task automatic test_abort();
        int  r0, np, nr, r1;
        bit  ok;
        @(negedge sys_clk) init_end = 1'b0;
        do_reset();
        wait_idle(ok);
        first_beats = SECTOR_WORDS;
        busy_delay  = 2;
        load_id++;
        r0 = req_q.size();
        @(negedge sys_clk) init_end = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(negedge sys_clk);
            if (req_q.size() >= r0 + 8) ok = 1'b1;
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL abort_reach_img3: got %0d requests expected 8", req_q.size() - r0); end
        if (ok) begin
            vectors++; if (req_q[r0 + 7] !== 32'd107) begin miscompares++; $display("FAIL abort_img3_sec1_addr: got %0d expected 107", req_q[r0 + 7]); end
        end
        repeat (40) @(negedge sys_clk);
        init_end = 1'b0;
        np = act_data.size(); nr = req_q.size();
        repeat (300) @(negedge sys_clk);
        vectors++; if (act_data.size() != np) begin miscompares++; $display("FAIL abort_pushes: got %0d extra expected 0", act_data.size() - np); end
        vectors++; if (req_q.size() != nr) begin miscompares++; $display("FAIL abort_requests: got %0d extra expected 0", req_q.size() - nr); end
        vectors++; if (photo_idx !== 3'd0) begin miscompares++; $display("FAIL abort_photo_idx: got %0d expected 0", photo_idx); end
        vectors++; if (all_photo_en !== 1'b0) begin miscompares++; $display("FAIL abort_all_en: got %b expected 0", all_photo_en); end
        wait_idle(ok);
        r1 = req_q.size();
        load_id++;
        init_end = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge sys_clk);
            if (req_q.size() > r1) ok = 1'b1;
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL abort_restart_req: got 0 requests expected 1"); end
        if (ok) begin
            vectors++; if (req_q[r1] !== 32'd100) begin miscompares++; $display("FAIL abort_restart_addr: got %0d expected 100", req_q[r1]); end
        end
        vectors++; if (photo_idx !== 3'd0) begin miscompares++; $display("FAIL abort_restart_idx: got %0d expected 0", photo_idx); end
        wait_all(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL abort_reload_timeout: got 0 expected 1"); end
        vectors++; if (req_q.size() - r1 != TOTAL_SECT) begin miscompares++; $display("FAIL abort_reload_reqs: got %0d expected %0d", req_q.size() - r1, TOTAL_SECT); end
    endtask

    task automatic test_back_to_back();
        @(negedge sys_clk) init_end = 1'b0;
        do_reset();
        test_full_load(SECTOR_WORDS, 0, "b2b");
    endtask

    initial begin
        test_reset();
        test_full_load(SECTOR_WORDS, 2, "full");
        test_done_hold();
        test_reset_after_done();
        test_overlong();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
